// File: rtl/mem_burst_master.sv
// mem_burst_master: burst load/store master for a word-addressed data memory.
// Requests carry a base word address, a beat count and a scalar/vector flag;
// stores stream beats from wr_* to the memory, loads stream memory words out
// on rd_* with a one-entry output register and backpressure.
//
// Optional feature: define MEM_BURST_MASTER_ERRCHK_EN to enable request range
// checking (misaligned vector base, or burst end beyond word 120999). Rejected
// requests finish immediately with err=1. Without the macro err is tied to 0.
module mem_burst_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_vf,
    input  logic [31:0]      req_base,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [127:0]     wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [127:0]     rd_data,
    output logic             rd_last,
    output logic             mem_we,
    output logic             mem_vf,
    output logic [127:0]     mem_addr,
    output logic [127:0]     mem_wd,
    input  logic [127:0]     mem_rd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [31:0]        addr;
    logic [LEN_W-1:0]   cnt;
    logic               vf_q;

    logic [31:0]        stride;
    logic               last_beat;
    logic               rd_take;
    logic [127:0]       rd_word;
    logic               req_bad;

    // Beat stride, final-beat detect and load-data formatting.
    always_comb begin
        stride    = vf_q ? 32'd4 : 32'd1;
        last_beat = (cnt == {{(LEN_W-1){1'b0}}, 1'b1});
        rd_take   = (state == READ) && (!rd_valid || rd_ready);
        rd_word   = vf_q ? mem_rd : {96'b0, mem_rd[31:0]};
    end

    // State-decoded outputs; mem_we follows wr_valid directly in WRITE.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        wr_ready  = (state == WRITE);
        mem_we    = (state == WRITE) && wr_valid;
        mem_wd    = (state == WRITE) ? wr_data : '0;
        mem_vf    = (state != IDLE) ? vf_q : 1'b0;
        mem_addr  = {96'b0, addr};
    end

`ifdef MEM_BURST_MASTER_ERRCHK_EN
    localparam logic [63:0] ADDR_LIMIT = 64'd121000;

    logic [63:0] req_span;
    logic [63:0] req_end;
    logic        err_q;

    // Range check on the offered request; the end address is computed
    // one past the last word, in 64 bits so it cannot wrap.
    always_comb begin
        req_span = req_vf ? (64'(req_len) << 2) : 64'(req_len);
        req_end  = 64'(req_base) + req_span;
        req_bad  = (req_vf && (req_base[1:0] != 2'b00)) || (req_end > ADDR_LIMIT);
    end

    // Error flag: captured at acceptance, presented alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            err_q <= req_bad;
        end else if (state == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign req_bad = 1'b0;
    assign err     = 1'b0;
`endif

    // Request sequencing, address/count tracking and the load output register.
    // The WRITE/READ state itself records the latched direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            vf_q     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr <= req_base;
                        cnt  <= req_len;
                        vf_q <= req_vf;
                        if (req_bad || (req_len == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (req_write) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                WRITE: begin
                    if (wr_valid) begin
                        addr <= addr + stride;
                        cnt  <= cnt - 1'b1;
                        if (last_beat) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (rd_take) begin
                        rd_data  <= rd_word;
                        rd_valid <= 1'b1;
                        rd_last  <= last_beat;
                        addr     <= addr + stride;
                        cnt      <= cnt - 1'b1;
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Parameter LEN_W SHALL default to 16 and set the req_len width in beats.
REQ-003 Port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port req_valid, input, 1 bit: a request is offered. Port req_ready, output, 1 bit: the block accepts it.
REQ-006 Port req_write, input, 1 bit: 1 means store, 0 means load. Port req_vf, input, 1 bit: 1 means 4-word vector beats, 0 means scalar beats.
REQ-007 Port req_base, input, 32 bits: first word address. Port req_len, input, LEN_W bits: beat count.
REQ-008 Port wr_valid, input, 1 bit; wr_ready, output, 1 bit; wr_data, input, 128 bits: store-data stream.
REQ-009 Port rd_valid, output, 1 bit; rd_ready, input, 1 bit; rd_data, output, 128 bits; rd_last, output, 1 bit: load-data stream.
REQ-010 Port mem_we, output, 1 bit; mem_vf, output, 1 bit; mem_addr, output, 128 bits; mem_wd, output, 128 bits; mem_rd, input, 128 bits: data-memory port.
REQ-011 Port busy, output, 1 bit: a request is in progress. Port done, output, 1 bit: one-cycle completion pulse. Port err, output, 1 bit: valid with done.

Function
REQ-012 The state machine SHALL have the states IDLE, WRITE, READ, DRAIN and DONE.
REQ-013 req_ready SHALL be 1 only in IDLE. A request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-014 On acceptance, the block SHALL latch base, len, vf and write. It then moves to WRITE or READ, or to DONE when len is 0. A zero-length request performs no memory access.
REQ-015 The beat stride SHALL be 4 when vf is 1 and 1 otherwise.
REQ-016 mem_addr SHALL be the current beat address zero-extended to 128 bits.
REQ-017 mem_vf SHALL equal the latched vf while busy and 0 otherwise.
REQ-018 In WRITE, wr_ready SHALL be 1.
REQ-019 In WRITE, mem_we SHALL equal wr_valid, as a combinational function of the registered state, and mem_wd SHALL equal wr_data.
REQ-020 In WRITE, each handshake beat SHALL advance the address by the stride and decrement the remaining count.
REQ-021 A WRITE cycle without wr_valid SHALL hold the address and count.
REQ-022 After the final write beat, the block SHALL go to DONE.
REQ-023 mem_we SHALL be 0 in every state other than WRITE.
REQ-024 In READ, the memory returns data on the falling edge. On the next rising edge, when rd_valid is 0 or rd_ready is 1, the block SHALL capture mem_rd into rd_data, set rd_valid and advance.
REQ-025 If rd_valid is 1 and rd_ready is 0, the block SHALL hold the address, count and rd_data.
REQ-026 With vf 0, rd_data SHALL be {96'b0, mem_rd[31:0]}. With vf 1, rd_data SHALL be all of mem_rd.
REQ-027 rd_last SHALL be 1 with the final beat.
REQ-028 After the final beat is captured, the block SHALL enter DRAIN. From DRAIN it goes to DONE on the cycle that final beat is accepted.
REQ-029 rd_valid SHALL clear on acceptance when no new beat is captured.
REQ-030 In DONE, done SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 When the beat count is 1, the first beat is also the last. Throughput SHALL be one beat per cycle when the streams never stall.

Reset
REQ-033 Asserting rst at any time SHALL force IDLE, abandon any request in flight, and set all of these to 0: outputs, the address and count registers, rd_valid, done and err.
REQ-034 No mem_we pulse SHALL occur while rst is 1, or in the cycle rst deasserts.

Configuration
REQ-035 Macro MEM_BURST_MASTER_ERRCHK_EN SHALL select request range checking.
REQ-036 With the macro defined, an accepted request SHALL be rejected when either condition holds:
- vf is 1 and base[1:0] is not 0;
- base + len*stride - 1 exceeds 120999, evaluated without overflow.
REQ-037 A rejected request SHALL make no memory access, go straight to DONE, and pulse done with err set to 1.
REQ-038 With the macro undefined, err SHALL be tied to 0, and every request SHALL execute as issued.

Verification
REQ-039 Store, vf=1, base=0, len=2, data A then B, wr_valid always 1: mem_we=1 for two cycles, mem_addr 0 then 4, mem_wd A then B, done one cycle after the second beat.
REQ-040 Load, vf=0, base=120000, len=3, rd_ready held 0 for 2 cycles after the first beat: rd_data holds word[120000] during the stall, then word[120001] and word[120002]; rd_last only on the third beat.
REQ-041 Zero-length load at base 5: no rd_valid and no mem_we, done one cycle after acceptance, busy for exactly 1 cycle.
REQ-042 ERRCHK on, store vf=1 base=2 len=1: mem_we stays 0, and done=1 with err=1. ERRCHK on, load vf=0 base=120999 len=2: err=1. ERRCHK off, the same requests: err=0, and the accesses are issued.
REQ-043 Assert rst mid-store after 1 of 4 beats: mem_we=0 immediately, busy=0, and a new request is accepted one cycle after rst deasserts.
REQ-044 Back-to-back requests with req_valid held high: the second is accepted on the first IDLE cycle after DONE.
